// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter and busy scoreboard for the register file's single write port.
// Optional WB_BUFFER_EN adds a 2-entry FIFO in front of the multi-cycle (port 1) path.
module rf_wb_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_valid,
  input  logic [4:0]            p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_data,
  output logic                  p0_stall,
  input  logic                  p1_valid,
  output logic                  p1_ready,
  input  logic [4:0]            p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_data,
  input  logic                  issue_valid,
  input  logic [4:0]            issue_addr,
  input  logic [4:0]            rs_addr,
  input  logic [4:0]            rt_addr,
  output logic                  rs_busy,
  output logic                  rt_busy,
  output logic                  RegWrite,
  output logic [4:0]            RdAddr,
  output logic [DATA_WIDTH-1:0] RdData
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  logic [CW-1:0]         starve_q, starve_d;
  logic [31:0]           busy_q, busy_d;
  logic                  cand_valid;
  logic [4:0]            cand_addr;
  logic [DATA_WIDTH-1:0] cand_data;
  logic                  p0_req, p1_req, forced, grant0, grant1;

`ifdef WB_BUFFER_EN
  logic [4:0]            fa_q [2];
  logic [DATA_WIDTH-1:0] fd_q [2];
  logic                  wptr_q, rptr_q;
  logic [1:0]            cnt_q;
  logic                  push, pop;

  assign cand_valid = (cnt_q != 2'd0);
  assign cand_addr  = fa_q[rptr_q];
  assign cand_data  = fd_q[rptr_q];
  assign p1_ready   = !rst && (cnt_q != 2'd2);
  // Address-0 requests are acknowledged but never stored, so the head is always a real write.
  assign push       = p1_valid && p1_ready && (p1_addr != 5'd0);
  assign pop        = grant1;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (push) begin
        fa_q[wptr_q] <= p1_addr;
        fd_q[wptr_q] <= p1_data;
        wptr_q       <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end
`else
  assign cand_valid = p1_valid;
  assign cand_addr  = p1_addr;
  assign cand_data  = p1_data;
  assign p1_ready   = !rst && p1_valid && ((p1_addr == 5'd0) || grant1);
`endif

  assign p0_req   = !rst && p0_valid && (p0_addr != 5'd0);
  assign p1_req   = !rst && cand_valid && (cand_addr != 5'd0);
  assign forced   = p1_req && (starve_q == LIMIT_C);
  assign grant1   = p1_req && (forced || !p0_req);
  assign grant0   = p0_req && !grant1;
  assign p0_stall = grant1 && p0_req;

  assign RegWrite = grant0 || grant1;
  assign RdAddr   = grant1 ? cand_addr : (grant0 ? p0_addr : 5'd0);
  assign RdData   = grant1 ? cand_data : (grant0 ? p0_data : '0);

  assign rs_busy = busy_q[rs_addr];
  assign rt_busy = busy_q[rt_addr];

  always_comb begin
    starve_d = starve_q;
    if (!p1_req || grant1)      starve_d = '0;
    else if (starve_q != LIMIT_C) starve_d = starve_q + 1'b1;
  end

  // Issue is applied after the clear so a same-cycle set of the same bit wins.
  always_comb begin
    busy_d = busy_q;
    if (grant1) busy_d[cand_addr] = 1'b0;
    if (issue_valid && (issue_addr != 5'd0)) busy_d[issue_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      busy_q   <= '0;
    end else begin
      starve_q <= starve_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed steps plus randomized traffic
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_rf_wb_arbiter;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic          clk;
  logic          rst;
  logic          p0_valid, p1_valid, issue_valid;
  logic [4:0]    p0_addr, p1_addr, issue_addr, rs_addr, rt_addr;
  logic [DW-1:0] p0_data, p1_data;
  logic          p0_stall, p1_ready, rs_busy, rt_busy, RegWrite;
  logic [4:0]    RdAddr;
  logic [DW-1:0] RdData;

  int n_assert = 0;
  int n_fail   = 0;

  logic          o_we, o_stall, o_ready, o_rsb, o_rtb;
  logic [4:0]    o_addr;
  logic [DW-1:0] o_data;

  int starve_m = 0;
  bit busy_m [32];
  int win_m;

  rf_wb_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_data(p0_data), .p0_stall(p0_stall),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_data(p1_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .RegWrite(RegWrite), .RdAddr(RdAddr), .RdData(RdData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

`ifndef WB_BUFFER_EN
  // Reference: port 1 wins when it wants the port and either port 0 is idle or it has
  // already been refused LIMIT cycles in a row.
  task automatic model_check();
    bit w0, w1;
    logic [4:0]    ea;
    logic [DW-1:0] ed;
    w0 = p0_valid && (p0_addr != 0);
    w1 = p1_valid && (p1_addr != 0);
    win_m = -1;
    if (!rst) begin
      if (w1 && (starve_m == LIMIT || !w0)) win_m = 1;
      else if (w0) win_m = 0;
    end
    ea = (win_m == 1) ? p1_addr : (win_m == 0) ? p0_addr : 5'd0;
    ed = (win_m == 1) ? p1_data : (win_m == 0) ? p0_data : '0;
    chk("m_regwrite", 64'(o_we), 64'(win_m >= 0));
    chk("m_rdaddr", 64'(o_addr), 64'(ea));
    chk("m_rddata", 64'(o_data), 64'(ed));
    chk("m_p0_stall", 64'(o_stall), 64'(!rst && win_m == 1 && w0));
    chk("m_p1_ready", 64'(o_ready), 64'(!rst && p1_valid && (p1_addr == 0 || win_m == 1)));
    chk("m_rs_busy", 64'(o_rsb), 64'(busy_m[rs_addr]));
    chk("m_rt_busy", 64'(o_rtb), 64'(busy_m[rt_addr]));
  endtask

  task automatic model_update();
    if (rst) begin
      starve_m = 0;
      foreach (busy_m[i]) busy_m[i] = 1'b0;
    end else begin
      if (win_m == 1) starve_m = 0;
      else if (p1_valid && p1_addr != 0) starve_m = (starve_m < LIMIT) ? starve_m + 1 : LIMIT;
      else starve_m = 0;
      if (win_m == 1) busy_m[p1_addr] = 1'b0;
      if (issue_valid && issue_addr != 0) busy_m[issue_addr] = 1'b1;
    end
  endtask
`endif

  task automatic cyc(input bit r, input bit v0, input logic [4:0] a0, input logic [DW-1:0] d0,
                     input bit v1, input logic [4:0] a1, input logic [DW-1:0] d1,
                     input bit iv, input logic [4:0] ia, input logic [4:0] rsa, input logic [4:0] rta);
    rst = r; p0_valid = v0; p0_addr = a0; p0_data = d0;
    p1_valid = v1; p1_addr = a1; p1_data = d1;
    issue_valid = iv; issue_addr = ia; rs_addr = rsa; rt_addr = rta;
    @(negedge clk);
    o_we = RegWrite; o_addr = RdAddr; o_data = RdData;
    o_stall = p0_stall; o_ready = p1_ready; o_rsb = rs_busy; o_rtb = rt_busy;
`ifndef WB_BUFFER_EN
    model_check();
`endif
    @(posedge clk);
`ifndef WB_BUFFER_EN
    model_update();
`endif
    #1;
  endtask

  initial begin
    foreach (busy_m[i]) busy_m[i] = 1'b0;
    win_m = -1;
    rst = 1'b1; p0_valid = 0; p1_valid = 0; issue_valid = 0;
    p0_addr = 0; p1_addr = 0; issue_addr = 0; rs_addr = 0; rt_addr = 0;
    p0_data = 0; p1_data = 0;
    @(posedge clk); #1;

    // Reset with live requests: nothing may be written or acknowledged.
    cyc(1, 1, 5, 32'hDEADBEEF, 1, 9, 32'h1, 1, 3, 3, 3);
    chk("rst_regwrite", 64'(o_we), 64'(0));
    chk("rst_p1_ready", 64'(o_ready), 64'(0));
    chk("rst_p0_stall", 64'(o_stall), 64'(0));
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3);
    chk("post_rst_rs_busy", 64'(o_rsb), 64'(0));

`ifndef WB_BUFFER_EN
    cyc(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    chk("p0_we", 64'(o_we), 64'(1));
    chk("p0_addr", 64'(o_addr), 64'(5));
    chk("p0_data", 64'(o_data), 64'hDEADBEEF);
    chk("p0_nostall", 64'(o_stall), 64'(0));

    cyc(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    chk("issue_same_cycle", 64'(o_rsb), 64'(0));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    chk("issue_busy", 64'(o_rsb), 64'(1));
    cyc(0, 0, 0, 0, 1, 7, 32'h1234, 0, 0, 7, 0);
    chk("p1_we", 64'(o_we), 64'(1));
    chk("p1_addr", 64'(o_addr), 64'(7));
    chk("p1_data", 64'(o_data), 64'h1234);
    chk("p1_ready", 64'(o_ready), 64'(1));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    chk("busy_cleared", 64'(o_rsb), 64'(0));

    for (int i = 0; i <= LIMIT; i++) begin
      cyc(0, 1, 3, 32'(100 + i), 1, 9, 32'h55, 0, 0, 0, 0);
      if (i < LIMIT) begin
        chk("starve_p0_addr", 64'(o_addr), 64'(3));
        chk("starve_p1_wait", 64'(o_ready), 64'(0));
        chk("starve_nostall", 64'(o_stall), 64'(0));
      end else begin
        chk("forced_addr", 64'(o_addr), 64'(9));
        chk("forced_data", 64'(o_data), 64'h55);
        chk("forced_stall", 64'(o_stall), 64'(1));
        chk("forced_ready", 64'(o_ready), 64'(1));
      end
    end
    cyc(0, 1, 3, 32'h77, 0, 0, 0, 0, 0, 0, 0);
    chk("p0_resume_addr", 64'(o_addr), 64'(3));
    chk("p0_resume_stall", 64'(o_stall), 64'(0));

    cyc(0, 1, 0, 32'hFF, 1, 0, 32'hEE, 1, 0, 0, 0);
    chk("zero_we", 64'(o_we), 64'(0));
    chk("zero_ready", 64'(o_ready), 64'(1));
    chk("zero_stall", 64'(o_stall), 64'(0));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("zero_rs_busy", 64'(o_rsb), 64'(0));

    cyc(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 4);
    cyc(0, 0, 0, 0, 1, 4, 32'h44, 1, 4, 0, 4);
    chk("setclr_we", 64'(o_addr), 64'(4));
    chk("setclr_before", 64'(o_rtb), 64'(1));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    chk("set_wins", 64'(o_rtb), 64'(1));

    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(0, 99) < 3,
          $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 99) < 55, 5'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 99) < 30, 5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
`else
    cyc(0, 1, 3, 32'h1, 1, 10, 32'hA, 0, 0, 0, 0);
    chk("buf_ready0", 64'(o_ready), 64'(1));
    chk("buf_p0_first", 64'(o_addr), 64'(3));
    cyc(0, 1, 3, 32'h2, 1, 11, 32'hB, 0, 0, 0, 0);
    chk("buf_ready1", 64'(o_ready), 64'(1));
    chk("buf_p0_second", 64'(o_addr), 64'(3));
    cyc(0, 1, 3, 32'h3, 1, 12, 32'hC, 0, 0, 0, 0);
    chk("buf_full", 64'(o_ready), 64'(0));
    cyc(1, 1, 3, 32'h4, 1, 12, 32'hC, 0, 0, 0, 0);
    chk("buf_rst_we", 64'(o_we), 64'(0));
    chk("buf_rst_ready", 64'(o_ready), 64'(0));
    cyc(0, 1, 3, 32'h5, 0, 0, 0, 0, 0, 0, 0);
    chk("buf_flushed_ready", 64'(o_ready), 64'(1));
    chk("buf_flushed_addr", 64'(o_addr), 64'(3));
    cyc(0, 0, 0, 0, 1, 13, 32'hD, 0, 0, 0, 0);
    chk("buf_accept_nowrite", 64'(o_we), 64'(0));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("buf_next_we", 64'(o_we), 64'(1));
    chk("buf_next_addr", 64'(o_addr), 64'(13));
    chk("buf_next_data", 64'(o_data), 64'hD);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
